// File: rtl/perceptron_mac_if.sv
// Beat-in / result-out handshake bundle for the perceptron MAC stage.
interface perceptron_mac_if #(
    parameter int ACC_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       x;
    logic [5:0]       w;
    logic             last;
    logic [ACC_W-1:0] thresh;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum;
    logic             fire;
    logic             ovf;

    modport master (
        output in_valid, x, w, last, thresh, out_ready,
        input  in_ready, out_valid, sum, fire, ovf
    );

    modport slave (
        input  in_valid, x, w, last, thresh, out_ready,
        output in_ready, out_valid, sum, fire, ovf
    );
endinterface

// File: rtl/perceptron_mac.sv
// Serial Q3.3 multiply-accumulate with saturation, then a threshold compare
// whose result is held until the downstream handshake completes.
module perceptron_mac #(
    parameter int ACC_W     = 10,
    parameter int MAX_TERMS = 16
) (
    input logic             clk,
    input logic             reset,
    perceptron_mac_if.slave bus
);
    localparam int CNT_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);

    typedef enum logic {ACCUM, OUT} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             sticky;

    logic [11:0]      prod_full;
    logic [8:0]       prod;
    logic [ACC_W:0]   sum_wide;
    logic             clip;
    logic [ACC_W-1:0] acc_next;
    logic             beat;
    logic             final_beat;

    // The carry out of a one-bit-wider add is exactly the saturation event.
    always_comb begin
        prod_full  = 12'(bus.x) * 12'(bus.w);
        prod       = prod_full[11:3];
        sum_wide   = {1'b0, acc} + (ACC_W+1)'(prod);
        clip       = sum_wide[ACC_W];
        acc_next   = clip ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        beat       = bus.in_valid && bus.in_ready;
        final_beat = bus.last || (count == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ACCUM;
            acc           <= '0;
            count         <= '0;
            sticky        <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.fire      <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        if (final_beat) begin
                            bus.sum       <= acc_next;
                            bus.fire      <= (acc_next >= bus.thresh);
                            bus.ovf       <= sticky || clip || !bus.last;
                            acc           <= '0;
                            count         <= '0;
                            sticky        <= 1'b0;
                            bus.in_ready  <= 1'b0;
                            bus.out_valid <= 1'b1;
                            state         <= OUT;
                        end else begin
                            acc    <= acc_next;
                            count  <= count + 1'b1;
                            sticky <= sticky || clip;
                        end
                    end
                end
                OUT: begin
                    // in_ready rises only after the handshake edge, giving the spare cycle.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule
